// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage, program ROM and core.
// The master modport is the fetch stage side. The slave modport is the ROM/core side.
interface instr_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);
  // ROM request/response
  logic               rom_req;
  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_valid;
  logic [INSTR_W-1:0] rom_data;
  // Core instruction handshake
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;
  // Control from the core
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  logic               halt;
  logic [ADDR_W-1:0]  fetch_pc;

  modport master (
    output rom_req, rom_addr, instr_out, instr_valid, fetch_pc,
    input  rom_valid, rom_data, instr_ready, jump_en, jump_addr, halt
  );

  modport slave (
    input  rom_req, rom_addr, instr_out, instr_valid, fetch_pc,
    output rom_valid, rom_data, instr_ready, jump_en, jump_addr, halt
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, single-outstanding ROM reader,
// DEPTH-entry prefetch FIFO, and jump (flush + redirect) and halt support.
module instr_fetch #(
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 12,
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,     // no request outstanding
    WAIT,     // request outstanding, response will be kept
    DISCARD   // request outstanding, response will be dropped
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic not_empty;
  logic pop;
  logic push;
  logic can_issue;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & bus.instr_ready;
  // A same-cycle pop frees a slot, so a full FIFO being drained may still issue.
  assign can_issue = rst_n & (state_q == IDLE) & ~bus.halt & ~bus.jump_en &
                     ((count_q - CNT_W'(pop)) < CNT_W'(DEPTH));
  assign push      = (state_q == WAIT) & bus.rom_valid & ~bus.jump_en;

  assign bus.rom_req     = can_issue;
  assign bus.rom_addr    = pc_q;
  assign bus.fetch_pc    = pc_q;
  assign bus.instr_valid = not_empty;
  assign bus.instr_out   = not_empty ? mem_q[rd_ptr_q] : '0;

  // Request FSM and program counter; a jump redirects and overrides any issue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else if (bus.jump_en) begin
      pc_q <= bus.jump_addr;
      // A request still in flight must be absorbed before issuing again.
      if (state_q != IDLE && !bus.rom_valid) state_q <= DISCARD;
      else                                   state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= WAIT;
          end
        end
        WAIT, DISCARD: begin
          if (bus.rom_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointer/occupancy next state; a jump empties the FIFO.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.jump_en) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which words are visible.
    if (push) mem_q[wr_ptr_q] <= bus.rom_data;
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a ROM responder with variable latency, a
// stream model of expected instructions, and directed plus random stimulus.
module tb_instr_fetch;
  localparam int          ADDR_W   = 8;
  localparam int          INSTR_W  = 12;
  localparam int          DEPTH    = 2;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam logic [7:0]  WRAP_PC  = 8'hFE;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if ();
  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) w_if ();

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.master));

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(w_if.master));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ROM contents: low byte is the address, so every word is unique and non-zero.
  function automatic logic [11:0] rom_word(input logic [7:0] a);
    return {a[3:0] ^ a[7:4] ^ 4'h5, a};
  endfunction

  // Reference model: consumed instructions form the sequential address stream
  // starting at the last reset/jump target; stored words and the single ROM
  // transaction are tracked to predict when a request is allowed.
  logic [11:0] exp_q[$];
  logic [7:0]  next_addr;
  logic [7:0]  issue_pc;
  int          stored;
  bit          rst_prev_low;
  bit          pend, live, owned;
  bit          resp_owned, resp_live;
  int          rem;
  logic [7:0]  p_addr;
  int          lat_min = 1;
  int          lat_max = 1;

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back(rom_word(next_addr));
      next_addr++;
    end
  endtask

  task automatic restart_stream(input logic [7:0] a);
    exp_q.delete();
    next_addr = a;
    top_up();
  endtask

  // ROM responder and scoreboard monitor for the main DUT.
  initial begin : rom_and_scoreboard
    bit busy, exp_req, exp_valid, consume, push;
    u_if.rom_valid = 1'b0;
    u_if.rom_data  = '0;
    stored = 0; issue_pc = RESET_PC; restart_stream(RESET_PC);
    pend = 0; live = 0; owned = 0; resp_owned = 0; resp_live = 0; rem = 0; p_addr = '0;
    rst_prev_low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("req_in_reset", u_if.rom_req, 0);
        if (rst_prev_low) begin
          check("valid_in_reset", u_if.instr_valid, 0);
          check("pc_in_reset", u_if.fetch_pc, RESET_PC);
        end
        stored = 0; issue_pc = RESET_PC; restart_stream(RESET_PC);
        if (pend) begin owned = 0; live = 0; end
        rst_prev_low = 1;
      end else begin
        rst_prev_low = 0;
        exp_valid = (stored > 0);
        consume   = exp_valid && u_if.instr_ready;
        busy      = (pend && owned) || (u_if.rom_valid && resp_owned);
        exp_req   = !busy && !u_if.halt && !u_if.jump_en && ((stored - int'(consume)) < DEPTH);
        check("instr_valid", u_if.instr_valid, exp_valid);
        if (exp_valid) check("instr_out", u_if.instr_out, exp_q[0]);
        else           check("nop_when_empty", u_if.instr_out, 0);
        check("fetch_pc", u_if.fetch_pc, issue_pc);
        check("rom_req", u_if.rom_req, exp_req);
        if (u_if.rom_req) begin
          if (exp_req) check("rom_addr", u_if.rom_addr, issue_pc);
          pend = 1; live = 1; owned = 1;
          rem = $urandom_range(lat_min, lat_max);
          p_addr = u_if.rom_addr;
        end
        if (exp_req) issue_pc++;
        push = u_if.rom_valid && resp_owned && resp_live && !u_if.jump_en;
        if (u_if.jump_en) begin
          stored = 0;
          issue_pc = u_if.jump_addr;
          restart_stream(u_if.jump_addr);
          if (pend) live = 0;
        end else begin
          if (consume) begin
            void'(exp_q.pop_front());
            top_up();
          end
          stored = stored + int'(push) - int'(consume);
        end
      end
      @(posedge clk); #1;
      if (pend && rem == 1) begin
        u_if.rom_valid = 1'b1;
        u_if.rom_data  = rom_word(p_addr);
        resp_owned = owned; resp_live = live;
        pend = 0;
      end else begin
        u_if.rom_valid = 1'b0;
        u_if.rom_data  = '0;
        resp_owned = 0; resp_live = 0;
        if (pend) rem--;
      end
    end
  end

  // Second instance with RESET_PC=FE: checks address wrap and its first words.
  initial begin : wrap_rom
    logic [7:0]  wa_q[$];
    logic [11:0] ww_q[$];
    bit          req;
    logic [7:0]  a;
    wa_q.push_back(8'hFE); wa_q.push_back(8'hFF); wa_q.push_back(8'h00); wa_q.push_back(8'h01);
    ww_q.push_back(rom_word(8'hFE)); ww_q.push_back(rom_word(8'hFF)); ww_q.push_back(rom_word(8'h00));
    a = '0;
    w_if.instr_ready = 1'b1; w_if.halt = 1'b0; w_if.jump_en = 1'b0; w_if.jump_addr = '0;
    w_if.rom_valid = 1'b0; w_if.rom_data = '0;
    forever begin
      @(negedge clk);
      req = 0;
      if (rst_n) begin
        if (w_if.rom_req) begin
          req = 1;
          a = w_if.rom_addr;
          if (wa_q.size() > 0) check("wrap_rom_addr", a, wa_q.pop_front());
        end
        if (w_if.instr_valid && ww_q.size() > 0) check("wrap_instr_out", w_if.instr_out, ww_q.pop_front());
      end
      @(posedge clk); #1;
      w_if.rom_valid = req;
      w_if.rom_data  = req ? rom_word(a) : '0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin : stimulus
    int got;
    bit found;
    rst_n = 1'b0;
    u_if.instr_ready = 1'b1; u_if.halt = 1'b0; u_if.jump_en = 1'b0; u_if.jump_addr = '0;
    run(3);
    @(negedge clk); #1;
    check("wrap_reset_pc", w_if.fetch_pc, WRAP_PC);
    check("reset_instr_out", u_if.instr_out, 0);

    // 1: release reset, 1-cycle ROM, ready=1; first valid two cycles later.
    step(); rst_n = 1'b1;
    got = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (u_if.instr_valid) begin got = i; break; end
    end
    check("first_valid_latency", got, 2);
    run(20);

    // 2: core stalls; FIFO fills and requests stop, then it drains in order.
    u_if.instr_ready = 1'b0;
    run(12);
    @(negedge clk); #1;
    check("stall_no_req", u_if.rom_req, 0);
    check("stall_full_valid", u_if.instr_valid, 1);
    step(); u_if.instr_ready = 1'b1;
    run(20);

    // 3: jump to 40 while a 3-cycle request is outstanding.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pend && live && rem == 3) begin found = 1; break; end
    end
    check("t3_wait_request", found, 1);
    step(); u_if.jump_en = 1'b1; u_if.jump_addr = 8'h40;
    step(); u_if.jump_en = 1'b0;
    @(negedge clk); #1;
    check("t3_empty_after_jump", u_if.instr_valid, 0);
    check("t3_fetch_pc", u_if.fetch_pc, 8'h40);
    run(20);

    // 4: jump in the same cycle as a ROM response and a pop.
    lat_min = 2; lat_max = 2;
    u_if.instr_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (stored >= 1 && pend && live && rem == 1) begin found = 1; break; end
    end
    check("t4_wait_setup", found, 1);
    step(); u_if.instr_ready = 1'b1; u_if.jump_en = 1'b1; u_if.jump_addr = 8'h80;
    @(negedge clk); #1;
    check("t4_head_present", u_if.instr_valid, 1);
    step(); u_if.jump_en = 1'b0;
    @(negedge clk); #1;
    check("t4_empty_after_jump", u_if.instr_valid, 0);
    check("t4_fetch_pc", u_if.fetch_pc, 8'h80);
    run(20);

    // 5: halt with a request in flight; word still delivered, FIFO drains.
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pend && live && rem == 2) begin found = 1; break; end
    end
    check("t5_wait_request", found, 1);
    step(); u_if.halt = 1'b1;
    run(10);
    @(negedge clk); #1;
    check("t5_halt_no_req", u_if.rom_req, 0);
    check("t5_drained", u_if.instr_valid, 0);
    check("t5_nop_out", u_if.instr_out, 0);
    step(); u_if.halt = 1'b0;
    run(10);

    // 6: reset during an outstanding request; the late response is ignored.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pend && live && rem == 3) begin found = 1; break; end
    end
    check("t6_wait_request", found, 1);
    step(); rst_n = 1'b0;
    step();
    @(negedge clk); #1;
    check("t6_reset_no_req", u_if.rom_req, 0);
    check("t6_reset_empty", u_if.instr_valid, 0);
    step(); rst_n = 1'b1; u_if.halt = 1'b1;
    step();
    @(negedge clk); #1;
    check("t6_late_valid_ignored", u_if.instr_valid, 0);
    step(); u_if.halt = 1'b0;
    run(20);

    // Random traffic: ready, halt, jumps and ROM latency all vary.
    lat_min = 1; lat_max = 4;
    repeat (1500) begin
      step();
      u_if.instr_ready = ($urandom_range(0, 3) != 0);
      u_if.halt        = ($urandom_range(0, 15) == 0);
      u_if.jump_en     = ($urandom_range(0, 24) == 0);
      u_if.jump_addr   = 8'($urandom);
    end
    step();
    u_if.jump_en = 1'b0; u_if.halt = 1'b0; u_if.instr_ready = 1'b1;
    run(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
